// File: rtl/id_stage_pkg.sv
// Shared RV32I/M decode constants and ALU op encodings, also consumed by the ex stage.
package id_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_LW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // M ops are {2'b10, funct3}, branch compares are {2'b11, funct3}.
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd16;
  localparam logic [4:0] ALU_BEQ  = 5'd24;

  typedef enum logic [1:0] { OP1_RS1, OP1_PC, OP1_ZERO } op1_sel_e;
  typedef enum logic [1:0] { OP2_RS2, OP2_IMM, OP2_FOUR } op2_sel_e;

  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_decoder.sv
// Combinational RV32I(+M) decoder: instruction, register data and PC to execute fields.
module id_decoder
  import id_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RADDR_W   = 5,
  parameter int SUPPORT_M = 0
) (
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  output logic [RADDR_W-1:0] rs1_addr_o,
  output logic [RADDR_W-1:0] rs2_addr_o,
  output logic [XLEN-1:0]  op1_o,
  output logic [XLEN-1:0]  op2_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [4:0]       alu_op_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic             reg_wen_o,
  output logic             mem_re_o,
  output logic             mem_we_o,
  output logic             branch_o,
  output logic             jump_o,
  output logic [2:0]       mem_size_o,
  output logic             illegal_o
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm32;
  logic        use_rs1, use_rs2, wen, re, we, br, jmp, ill;
  op1_sel_e    op1_sel;
  op2_sel_e    op2_sel;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];

  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    imm32    = '0;
    alu_op_o = ALU_ADD;
    wen      = 1'b0;
    re       = 1'b0;
    we       = 1'b0;
    br       = 1'b0;
    jmp      = 1'b0;
    ill      = 1'b0;
    op1_sel  = OP1_RS1;
    op2_sel  = OP2_IMM;
    case (opcode)
      OPC_LUI: begin
        imm32 = {inst_i[31:12], 12'b0}; op1_sel = OP1_ZERO; wen = 1'b1;
      end
      OPC_AUIPC: begin
        imm32 = {inst_i[31:12], 12'b0}; op1_sel = OP1_PC; wen = 1'b1;
      end
      OPC_JAL: begin
        imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        op1_sel = OP1_PC; op2_sel = OP2_FOUR; wen = 1'b1; jmp = 1'b1;
      end
      OPC_JALR: begin
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        use_rs1 = 1'b1; op2_sel = OP2_FOUR; wen = 1'b1; jmp = 1'b1;
      end
      OPC_BRANCH: begin
        imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        use_rs1 = 1'b1; use_rs2 = 1'b1; op2_sel = OP2_RS2; br = 1'b1;
        alu_op_o = {2'b11, f3};
      end
      OPC_LOAD: begin
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        use_rs1 = 1'b1; re = 1'b1; wen = 1'b1;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        use_rs1 = 1'b1; use_rs2 = 1'b1; we = 1'b1;
        ill = (f3 > 3'b010);
      end
      OPC_OP_IMM: begin
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        use_rs1 = 1'b1; wen = 1'b1;
        alu_op_o = alu_from_f3(f3, (f3 == F3_SRL_SRA) && inst_i[30]);
        // Shift-immediates carry shamt in imm[4:0]; only imm[10] (SRAI) may be set above it.
        if (f3 == F3_SLL)
          ill = (f7 != F7_BASE);
        else if (f3 == F3_SRL_SRA)
          ill = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; op2_sel = OP2_RS2; wen = 1'b1;
        if (f7 == F7_MULDIV) begin
          alu_op_o = {2'b10, f3};
          ill = (SUPPORT_M == 0);
        end else begin
          alu_op_o = alu_from_f3(f3, inst_i[30]);
          ill = !((f7 == F7_BASE) ||
                  ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
        end
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: ill = 1'b1;
    endcase
  end

  assign rs1_addr_o = use_rs1 ? RADDR_W'(inst_i[19:15]) : '0;
  assign rs2_addr_o = use_rs2 ? RADDR_W'(inst_i[24:20]) : '0;
  assign rd_addr_o  = RADDR_W'(inst_i[11:7]);
  assign imm_o      = XLEN'($signed(imm32));
  assign mem_size_o = f3;
  assign illegal_o  = ill;
  assign reg_wen_o  = wen && !ill && (inst_i[11:7] != 5'd0);
  assign mem_re_o   = re && !ill;
  assign mem_we_o   = we && !ill;
  assign branch_o   = br && !ill;
  assign jump_o     = jmp && !ill;

  always_comb begin
    case (op1_sel)
      OP1_PC:   op1_o = pc_i;
      OP1_ZERO: op1_o = '0;
      default:  op1_o = rs1_data_i;
    endcase
    case (op2_sel)
      OP2_RS2:  op2_o = rs2_data_i;
      OP2_FOUR: op2_o = XLEN'(4);
      default:  op2_o = imm_o;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: handshake with if_id/ex, load-use bubble insertion and flush.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RADDR_W   = 5,
  parameter int SUPPORT_M = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        inst_i,
  input  logic [XLEN-1:0]    inst_addr_i,
  output logic [RADDR_W-1:0] rs1_addr_o,
  output logic [RADDR_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic               ex_load_valid,
  input  logic [RADDR_W-1:0] ex_load_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        inst_o,
  output logic [XLEN-1:0]    inst_addr_o,
  output logic [XLEN-1:0]    op1_o,
  output logic [XLEN-1:0]    op2_o,
  output logic [XLEN-1:0]    store_data_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [4:0]         alu_op_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               reg_wen,
  output logic               mem_re_o,
  output logic               mem_we_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic [2:0]         mem_size_o,
  output logic               illegal_o
);

  logic [XLEN-1:0]    op1_d, op2_d, imm_d;
  logic [4:0]         alu_op_d;
  logic [RADDR_W-1:0] rd_d;
  logic               wen_d, re_d, we_d, br_d, jmp_d, ill_d;
  logic [2:0]         size_d;
  logic               advance, hazard;

  id_decoder #(.XLEN(XLEN), .RADDR_W(RADDR_W), .SUPPORT_M(SUPPORT_M)) u_dec (
    .inst_i(inst_i), .pc_i(inst_addr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .op1_o(op1_d), .op2_o(op2_d),
    .imm_o(imm_d), .alu_op_o(alu_op_d), .rd_addr_o(rd_d), .reg_wen_o(wen_d),
    .mem_re_o(re_d), .mem_we_o(we_d), .branch_o(br_d), .jump_o(jmp_d),
    .mem_size_o(size_d), .illegal_o(ill_d)
  );

  // Unused rs fields decode to x0, so they can never match a non-zero load rd.
  assign hazard   = ex_load_valid && (ex_load_rd != '0) &&
                    ((ex_load_rd == rs1_addr_o) || (ex_load_rd == rs2_addr_o));
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      inst_o       <= '0;
      inst_addr_o  <= '0;
      op1_o        <= '0;
      op2_o        <= '0;
      store_data_o <= '0;
      imm_o        <= '0;
      alu_op_o     <= '0;
      rd_addr_o    <= '0;
      reg_wen      <= 1'b0;
      mem_re_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      branch_o     <= 1'b0;
      jump_o       <= 1'b0;
      mem_size_o   <= '0;
      illegal_o    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid && !hazard;
      if (in_valid && !hazard) begin
        inst_o       <= inst_i;
        inst_addr_o  <= inst_addr_i;
        op1_o        <= op1_d;
        op2_o        <= op2_d;
        store_data_o <= rs2_data_i;
        imm_o        <= imm_d;
        alu_op_o     <= alu_op_d;
        rd_addr_o    <= rd_d;
        reg_wen      <= wen_d;
        mem_re_o     <= re_d;
        mem_we_o     <= we_d;
        branch_o     <= br_d;
        jump_o       <= jmp_d;
        mem_size_o   <= size_d;
        illegal_o    <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage; a second instance covers SUPPORT_M=1.
module tb_id_stage;
  import id_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, ex_load_valid, flush, out_ready;
  logic [31:0] inst_i, inst_addr_i, rs1_data_i, rs2_data_i;
  logic [4:0]  ex_load_rd;

  logic        in_ready, out_valid, reg_wen, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o, alu_op_o;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, store_data_o, imm_o;
  logic [2:0]  mem_size_o;

  logic        m_in_ready, m_out_valid, m_reg_wen, m_mem_re, m_mem_we, m_branch, m_jump, m_illegal;
  logic [4:0]  m_rs1_addr, m_rs2_addr, m_rd_addr, m_alu_op;
  logic [31:0] m_inst, m_inst_addr, m_op1, m_op2, m_store_data, m_imm;
  logic [2:0]  m_mem_size;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .RADDR_W(5), .SUPPORT_M(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .ex_load_valid(ex_load_valid),
    .ex_load_rd(ex_load_rd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
    .store_data_o(store_data_o), .imm_o(imm_o), .alu_op_o(alu_op_o), .rd_addr_o(rd_addr_o),
    .reg_wen(reg_wen), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .branch_o(branch_o),
    .jump_o(jump_o), .mem_size_o(mem_size_o), .illegal_o(illegal_o)
  );

  id_stage #(.XLEN(32), .RADDR_W(5), .SUPPORT_M(1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .rs1_addr_o(m_rs1_addr), .rs2_addr_o(m_rs2_addr),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .ex_load_valid(ex_load_valid),
    .ex_load_rd(ex_load_rd), .flush(flush), .out_valid(m_out_valid), .out_ready(out_ready),
    .inst_o(m_inst), .inst_addr_o(m_inst_addr), .op1_o(m_op1), .op2_o(m_op2),
    .store_data_o(m_store_data), .imm_o(m_imm), .alu_op_o(m_alu_op), .rd_addr_o(m_rd_addr),
    .reg_wen(m_reg_wen), .mem_re_o(m_mem_re), .mem_we_o(m_mem_we), .branch_o(m_branch),
    .jump_o(m_jump), .mem_size_o(m_mem_size), .illegal_o(m_illegal)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; inst_i = ins; inst_addr_i = pc; rs1_data_i = r1; rs2_data_i = r2;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; ex_load_valid = 1'b0; ex_load_rd = '0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    check_vec("reset out_valid", 32'(out_valid), 32'd0);
    check_vec("reset op1", op1_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // ADDI x1, x2, -1; rs2 field (31) is not read, so a load to x31 is no hazard
    drive(1'b1, 32'hFFF10093, 32'h100, 32'd5, 32'd9);
    ex_load_valid = 1'b1; ex_load_rd = 5'd31;
    #1;
    check_vec("addi in_ready", 32'(in_ready), 32'd1);
    check_vec("addi rs1_addr", 32'(rs1_addr_o), 32'd2);
    check_vec("addi rs2_addr", 32'(rs2_addr_o), 32'd0);
    @(negedge clk);
    ex_load_valid = 1'b0;
    check_vec("addi out_valid", 32'(out_valid), 32'd1);
    check_vec("addi op1", op1_o, 32'd5);
    check_vec("addi op2", op2_o, 32'hFFFFFFFF);
    check_vec("addi rd", 32'(rd_addr_o), 32'd1);
    check_vec("addi reg_wen", 32'(reg_wen), 32'd1);
    check_vec("addi pc", inst_addr_o, 32'h100);

    // LW x5, 0(x1)
    drive(1'b1, 32'h0000A283, 32'h104, 32'h40, 32'd0);
    @(negedge clk);
    check_vec("lw mem_re", 32'(mem_re_o), 32'd1);
    check_vec("lw mem_size", 32'(mem_size_o), 32'd2);
    check_vec("lw op2", op2_o, 32'd0);

    // ADD x6, x5, x5 while the LW sits in ex: one bubble
    drive(1'b1, 32'h00528333, 32'h108, 32'd11, 32'd22);
    ex_load_valid = 1'b1; ex_load_rd = 5'd5;
    #1;
    check_vec("hazard in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_vec("bubble out_valid", 32'(out_valid), 32'd0);
    ex_load_valid = 1'b0;
    #1;
    check_vec("post-hazard in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_vec("add out_valid", 32'(out_valid), 32'd1);
    check_vec("add rd", 32'(rd_addr_o), 32'd6);
    check_vec("add op2", op2_o, 32'd22);
    check_vec("add alu_op", 32'(alu_op_o), 32'(ALU_ADD));

    // Backpressure 3 cycles with LUI x7 waiting upstream
    out_ready = 1'b0;
    drive(1'b1, 32'h123453B7, 32'h10C, 32'hAAAA, 32'hBBBB);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
      @(negedge clk);
      check_vec($sformatf("stall%0d rd", i), 32'(rd_addr_o), 32'd6);
      check_vec($sformatf("stall%0d inst", i), inst_o, 32'h00528333);
    end
    out_ready = 1'b1;
    #1;
    check_vec("release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_vec("lui op1", op1_o, 32'd0);
    check_vec("lui op2", op2_o, 32'h12345000);
    check_vec("lui rd", 32'(rd_addr_o), 32'd7);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check_vec("no dup out_valid", 32'(out_valid), 32'd0);

    // LUI x0 and MUL x3, x1, x2 on both SUPPORT_M variants
    drive(1'b1, 32'h12345037, 32'h110, 32'd0, 32'd0);
    @(negedge clk);
    check_vec("lui x0 reg_wen", 32'(reg_wen), 32'd0);
    drive(1'b1, 32'h022081B3, 32'h114, 32'd3, 32'd4);
    @(negedge clk);
    check_vec("mul M0 illegal", 32'(illegal_o), 32'd1);
    check_vec("mul M0 reg_wen", 32'(reg_wen), 32'd0);
    check_vec("mul M0 out_valid", 32'(out_valid), 32'd1);
    check_vec("mul M1 illegal", 32'(m_illegal), 32'd0);
    check_vec("mul M1 reg_wen", 32'(m_reg_wen), 32'd1);
    check_vec("mul M1 alu_op", 32'(m_alu_op), 32'(ALU_MUL));

    // Flush beats backpressure and a pending hazard
    out_ready = 1'b0; flush = 1'b1;
    drive(1'b1, 32'h00528333, 32'h118, 32'd0, 32'd0);
    ex_load_valid = 1'b1; ex_load_rd = 5'd5;
    #1;
    check_vec("flush in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_vec("flush out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; ex_load_valid = 1'b0; out_ready = 1'b1;

    // SW x2, 8(x1)
    drive(1'b1, 32'h0020A423, 32'h120, 32'h1000, 32'hDEADBEEF);
    @(negedge clk);
    check_vec("sw mem_we", 32'(mem_we_o), 32'd1);
    check_vec("sw op2", op2_o, 32'd8);
    check_vec("sw store_data", store_data_o, 32'hDEADBEEF);
    check_vec("sw reg_wen", 32'(reg_wen), 32'd0);
    // Store with funct3=011, load with funct3=011
    drive(1'b1, 32'h0020B423, 32'h124, 32'd0, 32'd0);
    @(negedge clk);
    check_vec("sd illegal", 32'(illegal_o), 32'd1);
    check_vec("sd mem_we", 32'(mem_we_o), 32'd0);
    drive(1'b1, 32'h0000B283, 32'h128, 32'd0, 32'd0);
    @(negedge clk);
    check_vec("ld illegal", 32'(illegal_o), 32'd1);
    check_vec("ld mem_re", 32'(mem_re_o), 32'd0);
    // JAL x1, +8
    drive(1'b1, 32'h008000EF, 32'h200, 32'd7, 32'd7);
    @(negedge clk);
    check_vec("jal op1", op1_o, 32'h200);
    check_vec("jal op2", op2_o, 32'd4);
    check_vec("jal imm", imm_o, 32'd8);
    check_vec("jal jump", 32'(jump_o), 32'd1);
    // SRAI x1, x1, 3 and a bad shift funct7
    drive(1'b1, 32'h4030D093, 32'h204, 32'h80000000, 32'd0);
    @(negedge clk);
    check_vec("srai alu_op", 32'(alu_op_o), 32'(ALU_SRA));
    check_vec("srai illegal", 32'(illegal_o), 32'd0);
    drive(1'b1, 32'h2030D093, 32'h208, 32'd0, 32'd0);
    @(negedge clk);
    check_vec("bad shift illegal", 32'(illegal_o), 32'd1);
    // Unknown opcode
    drive(1'b1, 32'h0000007F, 32'h20C, 32'd0, 32'd0);
    @(negedge clk);
    check_vec("bad opcode illegal", 32'(illegal_o), 32'd1);

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_vec("async rst out_valid", 32'(out_valid), 32'd0);
    check_vec("async rst inst", inst_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
